// File: rtl/register_writeback.sv
// register_writeback
//   Writeback end of the register-file interface. Owns the architectural
//   register file read by the operand-read stage, commits execute/memory
//   results (including a second destination such as RDX for IMUL as an
//   extra write cycle) and keeps a pending-write scoreboard so the read
//   stage stalls on RAW/WAW hazards.
//
// Ports
//   clk, reset_n            clock (rising edge), asynchronous active-low reset
//   issue*In                instruction issued by the read stage; sets pending bits
//   srcReg1/2*In            read-stage source operands checked for RAW hazards
//   hazardStallOut          combinational stall request to the read stage
//   wbValidIn/wbReadyOut    writeback handshake
//   wbDest*/wbResultIn      primary destination and result
//   wbSpecial*In            secondary destination and result
//   registerFileOut         current architectural register contents
//   wbDoneOut               one-cycle pulse per retired instruction
//   retireCountOut          retired-instruction counter (wraps)
module register_writeback #(
  parameter int                    NUM_REGS   = 16,
  parameter int                    DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] RSP_INIT   = '0
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 issueValidIn,
  input  logic [$clog2(NUM_REGS)-1:0]          issueDestRegIn,
  input  logic                                 issueDestValidIn,
  input  logic [$clog2(NUM_REGS)-1:0]          issueSpecialRegIn,
  input  logic                                 issueSpecialValidIn,
  input  logic [$clog2(NUM_REGS)-1:0]          srcReg1In,
  input  logic                                 srcReg1ValidIn,
  input  logic [$clog2(NUM_REGS)-1:0]          srcReg2In,
  input  logic                                 srcReg2ValidIn,
  output logic                                 hazardStallOut,
  input  logic                                 wbValidIn,
  output logic                                 wbReadyOut,
  input  logic [$clog2(NUM_REGS)-1:0]          wbDestRegIn,
  input  logic                                 wbDestValidIn,
  input  logic [DATA_WIDTH-1:0]                wbResultIn,
  input  logic [$clog2(NUM_REGS)-1:0]          wbSpecialRegIn,
  input  logic                                 wbSpecialValidIn,
  input  logic [DATA_WIDTH-1:0]                wbSpecialResultIn,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  registerFileOut,
  output logic                                 wbDoneOut,
  output logic [31:0]                          retireCountOut
);

  localparam int IDX_W   = $clog2(NUM_REGS);
  localparam int RSP_IDX = 4;

  typedef enum logic {IDLE, SPECIAL} state_t;

  state_t                              state_q, state_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                 pending_q, pending_d;
  logic [IDX_W-1:0]                    spec_reg_q, spec_reg_d;
  logic [DATA_WIDTH-1:0]               spec_res_q, spec_res_d;
  logic [31:0]                         retire_cnt_q, retire_cnt_d;
  logic                                done_q;

  logic                                wr_en;
  logic [IDX_W-1:0]                    wr_idx;
  logic [DATA_WIDTH-1:0]               wr_data;
  logic                                retire;
  logic [NUM_REGS-1:0]                 clr_mask;
  logic [NUM_REGS-1:0]                 set_mask;

  // A register being written this cycle still reads as pending: the stall
  // is taken from the registered scoreboard only, with no bypass.
  always_comb begin
    hazardStallOut = (srcReg1ValidIn      & pending_q[srcReg1In])      |
                     (srcReg2ValidIn      & pending_q[srcReg2In])      |
                     (issueDestValidIn    & pending_q[issueDestRegIn]) |
                     (issueSpecialValidIn & pending_q[issueSpecialRegIn]);
  end

  // Writeback FSM: IDLE accepts requests, SPECIAL spends one cycle on the
  // latched second destination before the instruction retires.
  always_comb begin
    state_d    = state_q;
    wbReadyOut = (state_q == IDLE);
    wr_en      = 1'b0;
    wr_idx     = '0;
    wr_data    = '0;
    spec_reg_d = spec_reg_q;
    spec_res_d = spec_res_q;
    retire     = 1'b0;
    clr_mask   = '0;
    case (state_q)
      IDLE: begin
        if (wbValidIn) begin
          if (wbDestValidIn) begin
            wr_en              = 1'b1;
            wr_idx             = wbDestRegIn;
            wr_data            = wbResultIn;
            clr_mask[wbDestRegIn] = 1'b1;
          end
          if (wbSpecialValidIn) begin
            spec_reg_d = wbSpecialRegIn;
            spec_res_d = wbSpecialResultIn;
            state_d    = SPECIAL;
          end else begin
            retire = 1'b1;
          end
        end
      end
      SPECIAL: begin
        // Written one cycle after the primary, so it wins when both
        // destinations name the same register.
        wr_en                = 1'b1;
        wr_idx               = spec_reg_q;
        wr_data              = spec_res_q;
        clr_mask[spec_reg_q] = 1'b1;
        retire               = 1'b1;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scoreboard next state. An issue that arrives while stalled is a protocol
  // violation and is dropped; a same-cycle set and clear leaves the bit set.
  always_comb begin
    set_mask = '0;
    if (issueValidIn && !hazardStallOut) begin
      if (issueDestValidIn)    set_mask[issueDestRegIn]    = 1'b1;
      if (issueSpecialValidIn) set_mask[issueSpecialRegIn] = 1'b1;
    end
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_idx] = wr_data;
    retire_cnt_d = retire_cnt_q + {31'd0, retire};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      spec_reg_q   <= '0;
      spec_res_q   <= '0;
      retire_cnt_q <= '0;
      done_q       <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
      end
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      spec_reg_q   <= spec_reg_d;
      spec_res_q   <= spec_res_d;
      retire_cnt_q <= retire_cnt_d;
      done_q       <= retire;
      regs_q       <= regs_d;
    end
  end

  assign registerFileOut = regs_q;
  assign wbDoneOut       = done_q;
  assign retireCountOut  = retire_cnt_q;

endmodule

// File: tb/tb_register_writeback.sv
module tb_register_writeback;

  localparam logic [63:0] RSP = 64'h7FFF_0000;

  logic              clk;
  logic              reset_n;
  logic              issueValidIn;
  logic [3:0]        issueDestRegIn;
  logic              issueDestValidIn;
  logic [3:0]        issueSpecialRegIn;
  logic              issueSpecialValidIn;
  logic [3:0]        srcReg1In;
  logic              srcReg1ValidIn;
  logic [3:0]        srcReg2In;
  logic              srcReg2ValidIn;
  logic              hazardStallOut;
  logic              wbValidIn;
  logic              wbReadyOut;
  logic [3:0]        wbDestRegIn;
  logic              wbDestValidIn;
  logic [63:0]       wbResultIn;
  logic [3:0]        wbSpecialRegIn;
  logic              wbSpecialValidIn;
  logic [63:0]       wbSpecialResultIn;
  logic [15:0][63:0] registerFileOut;
  logic              wbDoneOut;
  logic [31:0]       retireCountOut;

  register_writeback #(.NUM_REGS(16), .DATA_WIDTH(64), .RSP_INIT(RSP)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .issueValidIn        (issueValidIn),
    .issueDestRegIn      (issueDestRegIn),
    .issueDestValidIn    (issueDestValidIn),
    .issueSpecialRegIn   (issueSpecialRegIn),
    .issueSpecialValidIn (issueSpecialValidIn),
    .srcReg1In           (srcReg1In),
    .srcReg1ValidIn      (srcReg1ValidIn),
    .srcReg2In           (srcReg2In),
    .srcReg2ValidIn      (srcReg2ValidIn),
    .hazardStallOut      (hazardStallOut),
    .wbValidIn           (wbValidIn),
    .wbReadyOut          (wbReadyOut),
    .wbDestRegIn         (wbDestRegIn),
    .wbDestValidIn       (wbDestValidIn),
    .wbResultIn          (wbResultIn),
    .wbSpecialRegIn      (wbSpecialRegIn),
    .wbSpecialValidIn    (wbSpecialValidIn),
    .wbSpecialResultIn   (wbSpecialResultIn),
    .registerFileOut     (registerFileOut),
    .wbDoneOut           (wbDoneOut),
    .retireCountOut      (retireCountOut)
  );

  typedef struct packed {
    logic [3:0]  idx;
    logic [63:0] val;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   done_stim = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    issueValidIn = 0; issueDestRegIn = 0; issueDestValidIn = 0;
    issueSpecialRegIn = 0; issueSpecialValidIn = 0;
    srcReg1In = 0; srcReg1ValidIn = 0; srcReg2In = 0; srcReg2ValidIn = 0;
    wbValidIn = 0; wbDestRegIn = 0; wbDestValidIn = 0; wbResultIn = 0;
    wbSpecialRegIn = 0; wbSpecialValidIn = 0; wbSpecialResultIn = 0;
  endtask

  task automatic push_exp(input logic [3:0] idx, input logic [63:0] val, input logic [31:0] cnt);
    exp_t e;
    e.idx = idx; e.val = val; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_state(input string tag);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_reg%0d", tag, i), registerFileOut[i], (i == 4) ? RSP : 64'h0);
    chk({tag, "_cnt"}, {32'h0, retireCountOut}, 64'h0);
    chk({tag, "_ready"}, {63'h0, wbReadyOut}, 64'h1);
    chk({tag, "_done"}, {63'h0, wbDoneOut}, 64'h0);
  endtask

  // Monitor: every retire pulse must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && wbDoneOut) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_retire: wbDoneOut=1 with no retire expected, count=%0d", retireCountOut);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("retire_reg%0d", e.idx), registerFileOut[e.idx], e.val);
          chk("retire_count", {32'h0, retireCountOut}, {32'h0, e.cnt});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    #1;
    chk_reset_state("reset");
    for (int i = 0; i < 16; i++) begin
      srcReg1In = 4'(i); srcReg1ValidIn = 1;
      #1 chk($sformatf("reset_pending%0d", i), {63'h0, hazardStallOut}, 64'h0);
    end
    clear_inputs();

    // RAW on reg 3 until its writeback retires
    tick();
    issueValidIn = 1; issueDestRegIn = 3; issueDestValidIn = 1;
    #1 chk("issue3_nostall", {63'h0, hazardStallOut}, 64'h0);
    tick();
    clear_inputs();
    srcReg1In = 3; srcReg1ValidIn = 1;
    #1 chk("raw3_stall", {63'h0, hazardStallOut}, 64'h1);
    wbValidIn = 1; wbDestValidIn = 1; wbDestRegIn = 3; wbResultIn = 64'hDEAD_BEEF;
    push_exp(3, 64'hDEAD_BEEF, 1);
    #1 chk("raw3_stall_during_wb", {63'h0, hazardStallOut}, 64'h1);
    tick();
    wbValidIn = 0;
    #1 chk("raw3_released", {63'h0, hazardStallOut}, 64'h0);
    chk("reg3_written", registerFileOut[3], 64'hDEAD_BEEF);
    clear_inputs();

    // Dual destination RAX/RDX, with a request held during SPECIAL
    wbValidIn = 1; wbDestValidIn = 1; wbDestRegIn = 0; wbResultIn = 64'h1;
    wbSpecialValidIn = 1; wbSpecialRegIn = 2; wbSpecialResultIn = 64'h2;
    push_exp(2, 64'h2, 2);
    tick();
    chk("dual_c1_reg0", registerFileOut[0], 64'h1);
    chk("dual_c1_ready", {63'h0, wbReadyOut}, 64'h0);
    chk("dual_c1_reg2_old", registerFileOut[2], 64'h0);
    wbDestRegIn = 1; wbResultIn = 64'h11; wbSpecialValidIn = 0;
    push_exp(1, 64'h11, 3);
    tick();
    chk("dual_c2_reg2", registerFileOut[2], 64'h2);
    chk("dual_c2_ready", {63'h0, wbReadyOut}, 64'h1);
    chk("held_not_taken", registerFileOut[1], 64'h0);
    tick();
    clear_inputs();
    chk("held_taken", registerFileOut[1], 64'h11);

    // Same-cycle clear and set of reg 5: set wins
    wbValidIn = 1; wbDestValidIn = 1; wbDestRegIn = 5; wbResultIn = 64'h55;
    issueValidIn = 1; issueDestValidIn = 1; issueDestRegIn = 5;
    push_exp(5, 64'h55, 4);
    tick();
    clear_inputs();
    srcReg1In = 5; srcReg1ValidIn = 1;
    #1 chk("set_wins_stall5", {63'h0, hazardStallOut}, 64'h1);
    wbValidIn = 1; wbDestValidIn = 1; wbDestRegIn = 5; wbResultIn = 64'h56;
    push_exp(5, 64'h56, 5);
    tick();
    clear_inputs();
    srcReg2In = 5; srcReg2ValidIn = 1;
    #1 chk("reg5_released", {63'h0, hazardStallOut}, 64'h0);
    clear_inputs();

    // Issue while stalled is dropped
    issueValidIn = 1; issueDestValidIn = 1; issueDestRegIn = 9;
    tick();
    clear_inputs();
    srcReg1In = 9; srcReg1ValidIn = 1;
    issueValidIn = 1; issueDestValidIn = 1; issueDestRegIn = 10;
    #1 chk("stall9", {63'h0, hazardStallOut}, 64'h1);
    tick();
    clear_inputs();
    srcReg1In = 10; srcReg1ValidIn = 1;
    #1 chk("dropped_issue10", {63'h0, hazardStallOut}, 64'h0);
    issueDestRegIn = 9; issueDestValidIn = 1;
    #1 chk("waw9", {63'h0, hazardStallOut}, 64'h1);
    clear_inputs();
    wbValidIn = 1; wbDestValidIn = 1; wbDestRegIn = 9; wbResultIn = 64'h9;
    push_exp(9, 64'h9, 6);
    tick();
    clear_inputs();

    // Special == dest: special value is final
    wbValidIn = 1; wbDestValidIn = 1; wbDestRegIn = 7; wbResultIn = 64'hA;
    wbSpecialValidIn = 1; wbSpecialRegIn = 7; wbSpecialResultIn = 64'hB;
    push_exp(7, 64'hB, 7);
    tick();
    clear_inputs();
    chk("same_reg_first", registerFileOut[7], 64'hA);
    tick();
    chk("same_reg_final", registerFileOut[7], 64'hB);

    // Reset inside SPECIAL discards the latched write
    wbValidIn = 1; wbDestValidIn = 1; wbDestRegIn = 7; wbResultIn = 64'hC;
    wbSpecialValidIn = 1; wbSpecialRegIn = 7; wbSpecialResultIn = 64'hD;
    tick();
    clear_inputs();
    chk("pre_reset_special", {63'h0, wbReadyOut}, 64'h0);
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
    #1;
    chk_reset_state("special_reset");

    // Counter wrap on a no-destination retire
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt_q;
    #1 chk("cnt_preset", {32'h0, retireCountOut}, 64'hFFFF_FFFF);
    wbValidIn = 1;
    push_exp(4, RSP, 0);
    tick();
    clear_inputs();
    #1;
    for (int i = 0; i < 16; i++)
      chk($sformatf("nodest_reg%0d", i), registerFileOut[i], (i == 4) ? RSP : 64'h0);
    tick();
    tick();
    chk("done_single_pulse", {63'h0, wbDoneOut}, 64'h0);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
